// File: rtl/striping_pkg.sv
// Shared types and constants for the two-lane striping scheduler.
package striping_pkg;

  localparam int unsigned DataWDefault = 32;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Lane0 = 2'd1,
    Lane1 = 2'd2
  } state_e;

endpackage

// File: rtl/striping_scheduler_if.sv
// Upstream/downstream handshake bundle between a producer and the striping scheduler.
interface striping_scheduler_if
  import striping_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = 16
);

  logic              enable;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              ready_in_0;
  logic              ready_in_1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out_0;
  logic              valid_out_1;
  logic              selector;
  logic [CNT_W-1:0]  words_0;
  logic [CNT_W-1:0]  words_1;

  modport slave (
    input  enable, data_in, valid_in, ready_in_0, ready_in_1,
    output ready_out, data_out0, data_out1, valid_out_0, valid_out_1, selector, words_0, words_1
  );

  modport master (
    output enable, data_in, valid_in, ready_in_0, ready_in_1,
    input  ready_out, data_out0, data_out1, valid_out_0, valid_out_1, selector, words_0, words_1
  );

endinterface

// File: rtl/lane_out_reg.sv
// One downstream lane: single-entry output register with hold/refill and a delivered-word counter.
module lane_out_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  words,
  output logic              can_load
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              deliver;

  always_comb begin
    deliver  = valid_q && ready_in;
    // A full register that is draining this cycle can take a new word with no bubble.
    can_load = !valid_q || ready_in;
    data_d   = data_q;
    valid_d  = valid_q;
    words_d  = words_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (deliver) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      words_d = words_q + 1'b1;
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      words_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign words     = words_q;

endmodule

// File: rtl/striping_scheduler.sv
// Distributes an upstream word stream over two output lanes in bursts of BURST words.
module striping_scheduler
  import striping_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned BURST  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk_f,
  input logic                 reset,
  striping_scheduler_if.slave bus
);

  localparam logic [7:0] BurstLast = 8'(BURST - 1);

  state_e     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic       accept;
  logic       can_load_0, can_load_1;
  logic       load_0, load_1;

  always_comb begin
    bus.ready_out = !reset && (((state_q == Lane0) && can_load_0) ||
                               ((state_q == Lane1) && can_load_1));
    accept = bus.valid_in && bus.ready_out;
    load_0 = accept && (state_q == Lane0);
    load_1 = accept && (state_q == Lane1);
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      Idle: begin
        burst_d = '0;
        if (bus.enable) begin
          state_d = Lane0;
        end
      end
      Lane0, Lane1: begin
        // Disable wins over any accept happening in the same cycle.
        if (!bus.enable) begin
          state_d = Idle;
          burst_d = '0;
        end else if (accept) begin
          if (burst_q == BurstLast) begin
            state_d = (state_q == Lane0) ? Lane1 : Lane0;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = Idle;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q <= Idle;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  assign bus.selector = (state_q == Lane1);

  lane_out_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane_0 (
    .clk_f     (clk_f),
    .reset     (reset),
    .load      (load_0),
    .load_data (bus.data_in),
    .ready_in  (bus.ready_in_0),
    .data_out  (bus.data_out0),
    .valid_out (bus.valid_out_0),
    .words     (bus.words_0),
    .can_load  (can_load_0)
  );

  lane_out_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane_1 (
    .clk_f     (clk_f),
    .reset     (reset),
    .load      (load_1),
    .load_data (bus.data_in),
    .ready_in  (bus.ready_in_1),
    .data_out  (bus.data_out1),
    .valid_out (bus.valid_out_1),
    .words     (bus.words_1),
    .can_load  (can_load_1)
  );

endmodule

// File: tb/tb_striping_scheduler.sv
// Directed bench for striping_scheduler: three instances with BURST = 1, 3 and 2.
module tb_striping_scheduler;

  logic clk_f = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_f = ~clk_f;

  striping_scheduler_if #(.DATA_W(8), .CNT_W(4))  ia ();
  striping_scheduler_if #(.DATA_W(8), .CNT_W(16)) ib ();
  striping_scheduler_if #(.DATA_W(8), .CNT_W(16)) ic ();

  striping_scheduler #(.DATA_W(8), .BURST(1), .CNT_W(4)) u_dut_a (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (ia)
  );

  striping_scheduler #(.DATA_W(8), .BURST(3), .CNT_W(16)) u_dut_b (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (ib)
  );

  striping_scheduler #(.DATA_W(8), .BURST(2), .CNT_W(16)) u_dut_c (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (ic)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ia.enable = 0; ia.valid_in = 0; ia.data_in = '0; ia.ready_in_0 = 1; ia.ready_in_1 = 1;
    ib.enable = 0; ib.valid_in = 0; ib.data_in = '0; ib.ready_in_0 = 1; ib.ready_in_1 = 1;
    ic.enable = 0; ic.valid_in = 0; ic.data_in = '0; ic.ready_in_0 = 1; ic.ready_in_1 = 1;
    ia.valid_in = 1;
    tick();
    tick();
    check("rst_ready_out", 32'(ia.ready_out), 32'd0);
    check("rst_valid0", 32'(ia.valid_out_0), 32'd0);
    check("rst_valid1", 32'(ia.valid_out_1), 32'd0);
    check("rst_selector", 32'(ia.selector), 32'd0);
    check("rst_words0", 32'(ia.words_0), 32'd0);
    check("rst_data0", 32'(ia.data_out0), 32'd0);
    reset = 0;
    ia.valid_in = 0;

    // BURST=3: words 1..6, lane switch after the third accept.
    ib.enable = 1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      ib.valid_in = 1;
      ib.data_in  = 8'(k);
      tick();
      if (k <= 3) begin
        check("b_lane0_data", 32'(ib.data_out0), 32'(k));
        check("b_lane0_valid", 32'(ib.valid_out_0), 32'd1);
      end else begin
        check("b_lane1_data", 32'(ib.data_out1), 32'(k));
        check("b_lane1_valid", 32'(ib.valid_out_1), 32'd1);
      end
      check("b_selector", 32'(ib.selector), (k >= 3 && k < 6) ? 32'd1 : 32'd0);
    end
    ib.valid_in = 0;
    tick();
    check("b_words0", 32'(ib.words_0), 32'd3);
    check("b_words1", 32'(ib.words_1), 32'd3);

    // BURST=2: disable after one accept, drain in Idle, re-enable restarts on lane 0.
    ic.enable = 1; ic.ready_in_0 = 0;
    tick();
    ic.valid_in = 1; ic.data_in = 8'h11;
    tick();
    check("c_first_data0", 32'(ic.data_out0), 32'h11);
    check("c_first_sel", 32'(ic.selector), 32'd0);
    ic.enable = 0; ic.data_in = 8'h22;
    tick();
    ic.ready_in_0 = 1;
    settle();
    check("c_idle_ready_out", 32'(ic.ready_out), 32'd0);
    check("c_idle_holding", 32'(ic.valid_out_0), 32'd1);
    tick();
    check("c_drain_valid0", 32'(ic.valid_out_0), 32'd0);
    check("c_drain_valid1", 32'(ic.valid_out_1), 32'd0);
    check("c_drain_words0", 32'(ic.words_0), 32'd1);
    ic.enable = 1; ic.valid_in = 0;
    tick();
    check("c_reen_sel", 32'(ic.selector), 32'd0);
    ic.valid_in = 1; ic.data_in = 8'h33;
    settle();
    check("c_reen_ready_out", 32'(ic.ready_out), 32'd1);
    tick();
    check("c_reen_data0", 32'(ic.data_out0), 32'h33);
    ic.data_in = 8'h44;
    tick();
    check("c_burst_cleared_data0", 32'(ic.data_out0), 32'h44);
    check("c_burst_cleared_sel", 32'(ic.selector), 32'd1);
    ic.valid_in = 0;

    // BURST=1: A0..A3 alternate lanes with latency 1.
    ia.enable = 1;
    tick();
    settle();
    check("a_ready_after_enable", 32'(ia.ready_out), 32'd1);
    for (int k = 0; k < 4; k++) begin
      ia.valid_in = 1;
      ia.data_in  = 8'(8'hA0 + k);
      tick();
      if (k % 2 == 0) begin
        check("a_alt_data0", 32'(ia.data_out0), 32'(8'hA0 + k));
        check("a_alt_valid0", 32'(ia.valid_out_0), 32'd1);
        check("a_alt_other1", 32'(ia.valid_out_1), 32'd0);
      end else begin
        check("a_alt_data1", 32'(ia.data_out1), 32'(8'hA0 + k));
        check("a_alt_valid1", 32'(ia.valid_out_1), 32'd1);
        check("a_alt_other0", 32'(ia.valid_out_0), 32'd0);
      end
    end
    ia.valid_in = 0;
    tick();
    check("a_words0", 32'(ia.words_0), 32'd2);
    check("a_words1", 32'(ia.words_1), 32'd2);
    check("a_valid0_drop", 32'(ia.valid_out_0), 32'd0);
    check("a_data0_hold", 32'(ia.data_out0), 32'hA2);

    // Lane 0 stalled for four cycles while holding 0x55.
    ia.ready_in_0 = 0; ia.valid_in = 1; ia.data_in = 8'h55;
    tick();
    check("a_stall_load", 32'(ia.data_out0), 32'h55);
    ia.data_in = 8'h66;
    tick();
    check("a_stall_lane1", 32'(ia.data_out1), 32'h66);
    check("a_stall_sel", 32'(ia.selector), 32'd0);
    ia.data_in = 8'h77;
    settle();
    check("a_stall_ready_out", 32'(ia.ready_out), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("a_stall_data0", 32'(ia.data_out0), 32'h55);
      check("a_stall_valid0", 32'(ia.valid_out_0), 32'd1);
      check("a_stall_ready", 32'(ia.ready_out), 32'd0);
    end
    ia.ready_in_0 = 1;
    settle();
    check("a_release_ready_out", 32'(ia.ready_out), 32'd1);
    tick();
    check("a_refill_data0", 32'(ia.data_out0), 32'h77);
    check("a_refill_valid0", 32'(ia.valid_out_0), 32'd1);
    check("a_refill_words0", 32'(ia.words_0), 32'd3);
    check("a_refill_words1", 32'(ia.words_1), 32'd3);
    ia.valid_in = 0;
    tick();
    check("a_final_valid0", 32'(ia.valid_out_0), 32'd0);
    check("a_final_words0", 32'(ia.words_0), 32'd4);

    // Reset while both lanes hold words, then counter wrap at CNT_W=4.
    ia.ready_in_0 = 0; ia.ready_in_1 = 0; ia.valid_in = 1; ia.data_in = 8'hC1;
    tick();
    ia.data_in = 8'hC0;
    tick();
    check("a_full_valid0", 32'(ia.valid_out_0), 32'd1);
    check("a_full_valid1", 32'(ia.valid_out_1), 32'd1);
    reset = 1; ia.valid_in = 0;
    tick();
    check("a_mrst_data0", 32'(ia.data_out0), 32'd0);
    check("a_mrst_data1", 32'(ia.data_out1), 32'd0);
    check("a_mrst_valid0", 32'(ia.valid_out_0), 32'd0);
    check("a_mrst_valid1", 32'(ia.valid_out_1), 32'd0);
    check("a_mrst_words0", 32'(ia.words_0), 32'd0);
    check("a_mrst_words1", 32'(ia.words_1), 32'd0);
    check("a_mrst_sel", 32'(ia.selector), 32'd0);
    check("a_mrst_ready_out", 32'(ia.ready_out), 32'd0);
    reset = 0; ia.ready_in_0 = 1; ia.ready_in_1 = 1;
    tick();
    for (int i = 0; i < 33; i++) begin
      ia.valid_in = 1;
      ia.data_in  = 8'(i + 16);
      tick();
      if (i == 0) begin
        check("a_post_rst_data0", 32'(ia.data_out0), 32'h10);
        check("a_post_rst_valid0", 32'(ia.valid_out_0), 32'd1);
        check("a_post_rst_valid1", 32'(ia.valid_out_1), 32'd0);
      end
    end
    ia.valid_in = 0;
    tick();
    check("a_wrap_words0", 32'(ia.words_0), 32'd1);
    check("a_wrap_words1", 32'(ia.words_1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/striping_scheduler.md
STRIPING_SCHEDULER -- requirements
Module: striping_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of datapath.
REQ-002 SHALL have parameter BURST, default 1, words sent to one lane before switching lanes (legal range 1..255).
REQ-003 SHALL have parameter CNT_W, default 16, width of per-lane delivered-word counters.
REQ-004 clk_f  input  1  single clock; all state updates on posedge clk_f.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk_f.
REQ-006 enable  input  1  scheduler run enable.
REQ-007 data_in  input  DATA_W  upstream word.
REQ-008 valid_in  input  1  upstream word valid.
REQ-009 ready_out  output  1  scheduler can accept the upstream word this cycle (combinational).
REQ-010 ready_in_0 / ready_in_1  input  1 each  lane 0 / lane 1 downstream ready.
REQ-011 data_out0 / data_out1  output  DATA_W each  registered lane words.
REQ-012 valid_out_0 / valid_out_1  output  1 each  registered lane valids.
REQ-013 selector  output  1  lane currently targeted (0 = lane 0, 1 = lane 1).
REQ-014 words_0 / words_1  output  CNT_W each  count of words delivered on each lane.

Function
REQ-015 Upstream accept SHALL occur on a cycle with valid_in && ready_out; downstream delivery on lane x SHALL occur on a cycle with valid_out_x && ready_in_x.
REQ-016 FSM states SHALL be IDLE, LANE0, LANE1; selector = 1 only in LANE1.
REQ-017 IDLE -> LANE0 when enable = 1; LANE0/LANE1 -> IDLE when enable = 0 (takes effect next edge, regardless of pending accept that cycle).
REQ-018 LANEx -> other lane on an accept when burst count = BURST-1; burst count then clears to 0; otherwise each accept increments burst count.
REQ-019 Entering IDLE SHALL clear burst count; leaving IDLE SHALL always enter LANE0.
REQ-020 ready_out SHALL be 1 only in LANE0/LANE1, and only when the targeted lane register is empty or is delivering in the same cycle.
REQ-021 Accepted word SHALL appear on the targeted lane's data/valid outputs the cycle after accept (latency 1); non-targeted lane unaffected.
REQ-022 While valid_out_x = 1 and ready_in_x = 0, data_out_x and valid_out_x SHALL hold stable.
REQ-023 Simultaneous delivery and refill on the same lane SHALL sustain one word per cycle with no bubble.
REQ-024 After delivery without refill, valid_out_x SHALL drop to 0; data_out_x SHALL hold its last value.
REQ-025 Lane registers SHALL continue to drain in IDLE; no new accepts in IDLE.
REQ-026 words_x SHALL increment by 1 per delivery on lane x and wrap from 2^CNT_W-1 to 0.
REQ-027 With BURST = 1 and both lanes always ready, consecutive accepted words SHALL alternate lane 0, lane 1, lane 0, ...

Reset
REQ-028 While reset = 1: state IDLE, selector 0, burst count 0, data_out0/1 = 0, valid_out_0/1 = 0, words_0/1 = 0, ready_out = 0.
REQ-029 Reset mid-operation SHALL discard words held in lane registers; first accept after reset release goes to lane 0.

Structure
REQ-030 A shared package striping_pkg SHALL hold the FSM state typedef (IDLE, LANE0, LANE1) and the DATA_W default constant.
REQ-031 Per-lane output register with hold/refill logic SHALL be a sub-module lane_out_reg, instantiated twice.

Verification
REQ-032 BURST=1, enable=1, both ready, data_in 0xA0..0xA3 back-to-back -> lane0 gets 0xA0, 0xA2; lane1 gets 0xA1, 0xA3; each 1 cycle after accept; words_0 = words_1 = 2.
REQ-033 BURST=3, both ready, six words 1..6 -> lane0 gets 1,2,3; lane1 gets 4,5,6; selector toggles after word 3 accept.
REQ-034 BURST=1, ready_in_0 = 0 for 4 cycles with lane0 holding 0x55 -> data_out0 = 0x55, valid_out_0 = 1 stable; ready_out = 0 while targeting lane 0; release -> delivery, words_0 += 1.
REQ-035 enable dropped after 1 accept with BURST=2 -> IDLE next cycle, ready_out = 0, pending word still drains; re-enable -> next word goes to lane 0.
REQ-036 Reset asserted while both lanes hold valid words -> next cycle all outputs 0, counters 0; CNT_W=4, 17 deliveries on lane 0 -> words_0 = 1 (wrap).
